ones_comp_seg_display: RTL



---
 rtl/ones_comp_pkg.sv | 27 ++
 rtl/seg7_encode.sv | 25 ++
 rtl/ones_comp_seg_display.sv | 118 +++++++++++
 3 files changed

// File: rtl/ones_comp_pkg.sv
// Shared constants for the ones'-complement result display: active-low
// segment patterns and digit anode patterns for the 4-digit board display.
package ones_comp_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  localparam logic [3:0] NEG_ZERO_CODE = 4'b1111;

  typedef enum logic {
    DIG_MAG  = 1'b0,
    DIG_SIGN = 1'b1
  } digit_sel_e;

endpackage

// File: rtl/seg7_encode.sv
// Combinational 3-bit magnitude to active-low 7-segment {g,f,e,d,c,b,a}.
module seg7_encode
  import ones_comp_pkg::*;
(
  input  logic [2:0] mag,
  output logic [6:0] seg
);

  // Digit lookup; default blanks the digit rather than showing garbage.
  always_comb begin
    seg = SEG_BLANK;
    case (mag)
      3'd0:    seg = SEG_0;
      3'd1:    seg = SEG_1;
      3'd2:    seg = SEG_2;
      3'd3:    seg = SEG_3;
      3'd4:    seg = SEG_4;
      3'd5:    seg = SEG_5;
      3'd6:    seg = SEG_6;
      3'd7:    seg = SEG_7;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ones_comp_seg_display.sv
// Holds the latest ones'-complement result and scans its magnitude and sign
// onto two active-low 7-segment digits; flags the negative-zero code.
module ones_comp_seg_display
  import ones_comp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] y_in,
  input  logic       y_valid,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       neg_zero
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [3:0]       hold_r;
  logic [CNT_W-1:0] cnt_r;
  digit_sel_e       sel_r;
  logic [6:0]       seg_r;
  logic [3:0]       an_r;
  logic             neg_zero_r;

  logic             sign_s;
  logic [2:0]       mag_s;
  logic             neg_zero_s;
  logic [6:0]       mag_seg_s;
  logic [6:0]       seg_nxt_s;
  logic [3:0]       an_nxt_s;

  // Sign/magnitude conversion; negative zero is shown as an unsigned 0.
  always_comb begin
    sign_s     = 1'b0;
    mag_s      = 3'd0;
    neg_zero_s = (hold_r == NEG_ZERO_CODE);
    if (neg_zero_s) begin
      sign_s = 1'b0;
      mag_s  = 3'd0;
    end else if (hold_r[3]) begin
      sign_s = 1'b1;
      mag_s  = ~hold_r[2:0];
    end else begin
      sign_s = 1'b0;
      mag_s  = hold_r[2:0];
    end
  end

  seg7_encode u_seg7_encode (
    .mag (mag_s),
    .seg (mag_seg_s)
  );

  // Next-cycle digit drive; exactly one anode is ever low.
  always_comb begin
    an_nxt_s  = AN_OFF;
    seg_nxt_s = SEG_BLANK;
    case (sel_r)
      DIG_MAG: begin
        an_nxt_s  = AN_DIG0;
        seg_nxt_s = mag_seg_s;
      end
      DIG_SIGN: begin
        an_nxt_s  = AN_DIG1;
        seg_nxt_s = sign_s ? SEG_MINUS : SEG_BLANK;
      end
      default: begin
        an_nxt_s  = AN_OFF;
        seg_nxt_s = SEG_BLANK;
      end
    endcase
  end

  // Result capture on the valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= 4'b0000;
    end else if (y_valid) begin
      hold_r <= y_in;
    end else begin
      hold_r <= hold_r;
    end
  end

  // Free-running refresh counter; digit select flips on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
      sel_r <= DIG_MAG;
    end else if (cnt_r == CNT_MAX) begin
      cnt_r <= {CNT_W{1'b0}};
      sel_r <= (sel_r == DIG_MAG) ? DIG_SIGN : DIG_MAG;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      sel_r <= sel_r;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r       <= AN_OFF;
      seg_r      <= SEG_BLANK;
      neg_zero_r <= 1'b0;
    end else begin
      an_r       <= an_nxt_s;
      seg_r      <= seg_nxt_s;
      neg_zero_r <= neg_zero_s;
    end
  end

  assign an       = an_r;
  assign seg      = seg_r;
  assign neg_zero = neg_zero_r;

endmodule
